// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - job controller for the NxN systolic matrix multiply
// Latches operands, steps the orchestrator and PE array through clear/run/capture, holds the result.
module matmul_sequencer #(
   parameter int WIDTH      = 16,
   parameter int N          = 3,
   parameter int ACC_WIDTH  = 2*WIDTH + $clog2(N) + 1,
   parameter int RUN_CYCLES = 3*N - 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start,
   output logic                                      start_ready,
   input  logic                                      abort,
   input  logic signed [N-1:0][N-1:0][WIDTH-1:0]     a_in,
   input  logic signed [N-1:0][N-1:0][WIDTH-1:0]     b_in,
   output logic signed [N-1:0][N-1:0][WIDTH-1:0]     a_lat,
   output logic signed [N-1:0][N-1:0][WIDTH-1:0]     b_lat,
   output logic                                      orch_rst_n,
   output logic                                      pe_clear,
   output logic                                      pe_en,
   input  logic signed [N-1:0][N-1:0][ACC_WIDTH-1:0] pe_acc,
   output logic signed [N-1:0][N-1:0][ACC_WIDTH-1:0] result,
   output logic                                      result_valid,
   input  logic                                      result_ready,
   output logic                                      busy,
   output logic [15:0]                               job_count
);

   localparam int CW = $clog2(RUN_CYCLES) + 1;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Control outputs are registered alongside the state so they never see an input combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         a_lat        <= '0;
         b_lat        <= '0;
         result       <= '0;
         job_count    <= '0;
         orch_rst_n   <= 1'b0;
         pe_clear     <= 1'b0;
         pe_en        <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         start_ready  <= 1'b1;
      end else if (abort) begin
         state        <= IDLE;
         cnt          <= '0;
         orch_rst_n   <= 1'b0;
         pe_clear     <= 1'b0;
         pe_en        <= 1'b0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         start_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_lat       <= a_in;
                  b_lat       <= b_in;
                  state       <= CLEAR;
                  pe_clear    <= 1'b1;
                  busy        <= 1'b1;
                  start_ready <= 1'b0;
               end
            end
            CLEAR: begin
               state      <= RUN;
               cnt        <= '0;
               pe_clear   <= 1'b0;
               orch_rst_n <= 1'b1;
               pe_en      <= 1'b1;
            end
            RUN: begin
               if (cnt == CW'(RUN_CYCLES - 1)) begin
                  state      <= CAPTURE;
                  cnt        <= '0;
                  orch_rst_n <= 1'b0;
                  pe_en      <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            CAPTURE: begin
               result       <= pe_acc;
               state        <= DONE;
               result_valid <= 1'b1;
            end
            DONE: begin
               if (result_ready) begin
                  job_count    <= job_count + 16'd1;
                  state        <= IDLE;
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  start_ready  <= 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               cnt          <= '0;
               orch_rst_n   <= 1'b0;
               pe_clear     <= 1'b0;
               pe_en        <= 1'b0;
               result_valid <= 1'b0;
               busy         <= 1'b0;
               start_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
